mem_line_responder: RTL

//   Memory-side responder for cache line fills and write-backs. Accepts one 128-bit

---
 rtl/mem_line_responder_pkg.sv | 18 +
 rtl/mem_line_responder_if.sv | 25 ++
 rtl/mem_line_responder_line_ram.sv | 27 ++
 rtl/mem_line_responder.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mem_line_responder_pkg.sv
// Shared definitions for the memory line responder: bus widths, counter width,
// default parameters and the FSM state encoding.
package mem_line_responder_pkg;

  localparam int LINE_BITS       = 128;
  localparam int OFFSET_BITS     = 4;
  localparam int ADDR_BITS       = 32;
  localparam int CNT_BITS        = 4;
  localparam int DEFAULT_LATENCY = 4;
  localparam int DEFAULT_LINES   = 1024;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_line_responder_if.sv
// Line request/response bus between the cache controller (master) and the
// memory-side responder (slave).
interface mem_line_responder_if;
  import mem_line_responder_pkg::*;

  logic                 req_valid;
  logic                 req_write;
  logic [ADDR_BITS-1:0] req_addr;
  logic [LINE_BITS-1:0] req_wdata;
  logic                 req_ready;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [LINE_BITS-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/mem_line_responder_line_ram.sv
// Line storage: LINES x 128-bit array, synchronous write, combinational read.
// Contents are deliberately not reset.
module line_ram
  import mem_line_responder_pkg::*;
#(
  parameter int LINES = DEFAULT_LINES,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [IDX_W-1:0]     index,
  input  logic [LINE_BITS-1:0] wdata,
  output logic [LINE_BITS-1:0] rdata
);

  logic [LINE_BITS-1:0] mem_r [LINES];

  assign rdata = mem_r[index];

  // Commit a write-back line on the clock edge where we is high.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[index] <= wdata;
    end
  end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder for cache line fills and write-backs: one request at a
// time, answered after LATENCY cycles, response held until the cache takes it.
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int LINES   = DEFAULT_LINES,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_line_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(LINES);
  localparam logic [CNT_BITS-1:0] LOAD_CNT = CNT_BITS'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > ((1 << CNT_BITS) - 1)) begin : g_bad_latency
      $error("mem_line_responder: LATENCY must be in 1..15");
    end
  endgenerate

  state_t               state_r, state_s;
  logic [CNT_BITS-1:0]  cnt_r, cnt_s;
  logic                 write_r, write_s;
  logic [IDX_W-1:0]     index_r, index_s;
  logic [LINE_BITS-1:0] wdata_r, wdata_s;
  logic                 req_ready_r, req_ready_s;
  logic                 resp_valid_r, resp_valid_s;
  logic [LINE_BITS-1:0] resp_rdata_r, resp_rdata_s;
  logic                 we_s;
  logic [LINE_BITS-1:0] ram_rdata_s;
  logic                 unused_addr_s;

  // Offset bits and the aliased upper address bits are intentionally dropped.
  assign unused_addr_s = ^{bus.req_addr[ADDR_BITS-1:OFFSET_BITS+IDX_W],
                           bus.req_addr[OFFSET_BITS-1:0]};

  line_ram #(.LINES(LINES), .IDX_W(IDX_W)) u_ram (
    .clock (clock),
    .we    (we_s),
    .index (index_r),
    .wdata (wdata_r),
    .rdata (ram_rdata_s)
  );

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;

  // State, latency counter, request capture and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      cnt_r        <= {CNT_BITS{1'b0}};
      write_r      <= 1'b0;
      index_r      <= {IDX_W{1'b0}};
      wdata_r      <= {LINE_BITS{1'b0}};
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= {LINE_BITS{1'b0}};
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      write_r      <= write_s;
      index_r      <= index_s;
      wdata_r      <= wdata_s;
      req_ready_r  <= req_ready_s;
      resp_valid_r <= resp_valid_s;
      resp_rdata_r <= resp_rdata_s;
    end
  end

  // Next-state and next-output logic for the accept / wait / respond sequence.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    write_s      = write_r;
    index_s      = index_r;
    wdata_s      = wdata_r;
    req_ready_s  = req_ready_r;
    resp_valid_s = resp_valid_r;
    resp_rdata_s = resp_rdata_r;
    we_s         = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_s     = bus.req_write;
          index_s     = bus.req_addr[OFFSET_BITS +: IDX_W];
          wdata_s     = bus.req_wdata;
          cnt_s       = LOAD_CNT;
          req_ready_s = 1'b0;
          state_s     = S_WAIT;
        end else begin
          req_ready_s = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_r == {CNT_BITS{1'b0}}) begin
          // Write commits here so a following read already sees the new line.
          we_s         = write_r;
          resp_rdata_s = write_r ? wdata_r : ram_rdata_s;
          resp_valid_s = 1'b1;
          state_s      = S_RESP;
        end else begin
          cnt_s = cnt_r - CNT_BITS'(1);
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_s = 1'b0;
          req_ready_s  = 1'b1;
          state_s      = S_IDLE;
        end else begin
          resp_valid_s = 1'b1;
        end
      end
      default: begin
        state_s      = S_IDLE;
        req_ready_s  = 1'b1;
        resp_valid_s = 1'b0;
      end
    endcase
  end

endmodule
